bp_mem_multiport_arb: RTL and testbench

Parametrised N-requester front end for the testbench memory model. It lets several FE/BE/mock clients share one bp_cce_mem_msg command/response port. Commands are arbitrated round-robin and forwarded with zero added latency. Responses return in order and are routed back to the issuing requester through a source-tag FIFO. A sticky protocol-error flag and an outstanding-request watchdog report faults.

---
 rtl/bp_mem_multiport_arb_pkg.sv | 22 ++
 rtl/bp_mem_tag_fifo.sv | 98 +++++++++
 rtl/bp_mem_multiport_arb.sv | 165 ++++++++++++++++
 tb/tb_bp_mem_multiport_arb.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_mem_multiport_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_multiport_arb_pkg
// Purpose  : Shared helpers for the multi-port memory front end: port-index
//            width function and the default requester tag type.
// Revision : 1.0 - initial release
// ============================================================================
package bp_mem_multiport_arb_pkg;

  // Bits needed to index n requesters (never less than one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_NUM_PORTS = 2;
  localparam int unsigned DEFAULT_TAG_W     = idx_width(DEFAULT_NUM_PORTS);

  // Tag identifying the requester that issued an in-flight command
  typedef logic [DEFAULT_TAG_W-1:0] bp_mem_tag_t;

endpackage
`default_nettype wire

// File: rtl/bp_mem_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_tag_fifo
// Purpose  : Circular tag FIFO recording which requester owns each in-flight
//            memory command. Pointers carry a wrap bit so full/empty are
//            distinguished without a separate counter.
// Revision : 1.0 - initial release
// ============================================================================
module bp_mem_tag_fifo #(
  parameter int unsigned depth_p = 4,
  parameter int unsigned width_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             push_i,
  input  logic [width_p-1:0]               push_data_i,
  input  logic                             pop_i,
  output logic [width_p-1:0]               head_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(depth_p+1)-1:0]     count_o
);

  localparam int unsigned IDX_W = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int unsigned CNT_W = $clog2(depth_p + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(depth_p - 1);

  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             wr_wrap_q, wr_wrap_d;
  logic             rd_wrap_q, rd_wrap_d;
  logic [width_p-1:0] mem_q [depth_p];
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign full_o  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_idx_q];

  // Occupancy from pointer distance; differing wrap bits mean the writer lapped
  always_comb begin
    if (wr_wrap_q == rd_wrap_q) begin
      count_o = CNT_W'(wr_idx_q) - CNT_W'(rd_idx_q);
    end else begin
      count_o = CNT_W'(depth_p) - CNT_W'(rd_idx_q) + CNT_W'(wr_idx_q);
    end
  end

  // Pointer advance modulo depth, toggling the wrap bit on rollover
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (push_ok) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (pop_ok) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Pointer registers; storage itself needs no reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_wrap_q <= wr_wrap_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  // Tag storage write
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_idx_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_mem_multiport_arb.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_multiport_arb
// Purpose  : N-requester front end sharing one memory command/response port.
//            Round-robin command arbitration, in-order response routing via a
//            source-tag FIFO, sticky protocol-error and watchdog flags.
// Revision : 1.0 - initial release
// ============================================================================
module bp_mem_multiport_arb
  import bp_mem_multiport_arb_pkg::*;
#(
  parameter int unsigned num_ports_p       = 2,
  parameter int unsigned mem_msg_width_p   = 128,
  parameter int unsigned outstanding_els_p = 4,
  parameter int unsigned timeout_cycles_p  = 1024
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_ports_p*mem_msg_width_p-1:0]    req_cmd_i,
  input  logic [num_ports_p-1:0]                    req_cmd_v_i,
  output logic [num_ports_p-1:0]                    req_cmd_ready_o,
  output logic [mem_msg_width_p-1:0]                req_resp_o,
  output logic [num_ports_p-1:0]                    req_resp_v_o,
  input  logic [num_ports_p-1:0]                    req_resp_yumi_i,
  output logic [mem_msg_width_p-1:0]                mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_ready_i,
  input  logic [mem_msg_width_p-1:0]                mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_yumi_o,
  output logic [$clog2(outstanding_els_p+1)-1:0]    outstanding_o,
  output logic                                      error_o,
  output logic                                      timeout_o
);

  localparam int unsigned TAG_W = idx_width(num_ports_p);
  localparam int unsigned CNT_W = $clog2(outstanding_els_p + 1);
  localparam int unsigned WD_W  = $clog2(timeout_cycles_p + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(timeout_cycles_p);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(timeout_cycles_p - 1);

  typedef logic [TAG_W-1:0] tag_t;

  logic [mem_msg_width_p-1:0] cmd_arr [num_ports_p];

  tag_t            rr_q, rr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
  logic            timeout_q, timeout_d;

  tag_t            sel;
  logic            sel_v;
  logic            grant;
  logic            spurious;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  tag_t            fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Unpack the flat command bus into one slice per requester
  for (genvar g = 0; g < int'(num_ports_p); g++) begin : g_unpack
    assign cmd_arr[g] = req_cmd_i[g*mem_msg_width_p +: mem_msg_width_p];
  end

  // Round-robin pick starting at the pointer; independent of memory ready
  always_comb begin : p_arb
    int unsigned cand;
    cand  = 0;
    sel   = '0;
    sel_v = 1'b0;
    for (int unsigned i = 0; i < num_ports_p; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= num_ports_p) begin
        cand = cand - num_ports_p;
      end
      if (!sel_v && req_cmd_v_i[tag_t'(cand)]) begin
        sel_v = 1'b1;
        sel   = tag_t'(cand);
      end
    end
  end

  // Command forward and grant; a full tag FIFO blocks even with a pending pop
  always_comb begin
    mem_cmd_o       = cmd_arr[sel];
    mem_cmd_v_o     = reset_n_i && sel_v && !fifo_full;
    grant           = mem_cmd_v_o && mem_cmd_ready_i;
    req_cmd_ready_o = '0;
    if (grant) begin
      req_cmd_ready_o[sel] = 1'b1;
    end
  end

  // Response routing to the oldest tag owner, or drop when nothing is owed
  always_comb begin
    req_resp_o      = mem_resp_i;
    req_resp_v_o    = '0;
    mem_resp_yumi_o = 1'b0;
    fifo_pop        = 1'b0;
    spurious        = 1'b0;
    if (reset_n_i && mem_resp_v_i) begin
      if (!fifo_empty) begin
        req_resp_v_o[fifo_head] = 1'b1;
        mem_resp_yumi_o         = req_resp_yumi_i[fifo_head];
        fifo_pop                = req_resp_yumi_i[fifo_head];
      end else begin
        mem_resp_yumi_o = 1'b1;
        spurious        = 1'b1;
      end
    end
  end

  // Next-state for pointer, watchdog and sticky fault flags
  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (32'(sel) == num_ports_p - 1) ? '0 : sel + tag_t'(1);
    end
    wd_d = wd_q;
    if (fifo_empty || fifo_pop) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end
    error_d   = error_q || spurious;
    timeout_d = timeout_q || (!fifo_empty && (wd_q == WD_TRIP));
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_q      <= '0;
      wd_q      <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  bp_mem_tag_fifo #(
    .depth_p (outstanding_els_p),
    .width_p (TAG_W)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (grant),
    .push_data_i (sel),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign outstanding_o = fifo_count;
  assign error_o       = error_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_multiport_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_mem_multiport_arb
// Purpose  : Scoreboard bench for the multi-port memory front end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_mem_multiport_arb;

  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 4;
  localparam int T = 8;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N*W-1:0] req_cmd_i;
  logic [N-1:0]   req_cmd_v_i;
  logic [N-1:0]   req_cmd_ready_o;
  logic [W-1:0]   req_resp_o;
  logic [N-1:0]   req_resp_v_o;
  logic [N-1:0]   req_resp_yumi_i;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  logic [2:0]     outstanding_o;
  logic           error_o;
  logic           timeout_o;

  typedef struct {
    int           port;
    logic [W-1:0] cmd;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bp_mem_multiport_arb #(
    .num_ports_p       (N),
    .mem_msg_width_p   (W),
    .outstanding_els_p (D),
    .timeout_cycles_p  (T)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .req_cmd_i       (req_cmd_i),
    .req_cmd_v_i     (req_cmd_v_i),
    .req_cmd_ready_o (req_cmd_ready_o),
    .req_resp_o      (req_resp_o),
    .req_resp_v_o    (req_resp_v_o),
    .req_resp_yumi_i (req_resp_yumi_i),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .outstanding_o   (outstanding_o),
    .error_o         (error_o),
    .timeout_o       (timeout_o)
  );

  // Memory model: response payload derived from the command
  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] c);
    return c ^ 32'hDEAD_0000;
  endfunction

  task automatic idle_inputs();
    req_cmd_i       = '0;
    req_cmd_v_i     = '0;
    req_resp_yumi_i = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_i      = '0;
    mem_resp_v_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    sb_q.delete();
  endtask

  // Memory answers the oldest outstanding command
  task automatic drive_mem_resp();
    if (sb_q.size() > 0) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_i      = mem_fn(sb_q[0].cmd);
      req_resp_yumi_i = '1;
    end
  endtask

  task automatic drain_responses(input string tag);
    logic [N-1:0] exp_v;
    while (sb_q.size() > 0) begin
      @(negedge clk_i);
      idle_inputs();
      drive_mem_resp();
      #1;
      exp_v = N'(1) << sb_q[0].port;
      n_checks++;
      if (req_resp_v_o !== exp_v || mem_resp_yumi_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_drain_route: resp_v=%b yumi=%b expected resp_v=%b yumi=1", tag, req_resp_v_o, mem_resp_yumi_o, exp_v);
      end
      n_checks++;
      if (req_resp_o !== mem_fn(sb_q[0].cmd)) begin
        n_fail++;
        $display("FAIL %s_drain_data: got %h expected %h", tag, req_resp_o, mem_fn(sb_q[0].cmd));
      end
      void'(sb_q.pop_front());
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL %s_drain_empty: outstanding=%0d expected 0", tag, outstanding_o);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      reset_n_i       = 1'b0;
      req_cmd_v_i     = 2'b11;
      req_cmd_i       = {32'h1111_1111, 32'h2222_2222};
      mem_cmd_ready_i = 1'b1;
      mem_resp_v_i    = 1'b1;
      req_resp_yumi_i = 2'b11;
      #1;
      n_checks++;
      if (req_cmd_ready_o !== 2'b00 || mem_cmd_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_cmd c=%0d: ready=%b cmd_v=%b expected 00/0", c, req_cmd_ready_o, mem_cmd_v_o);
      end
      n_checks++;
      if (req_resp_v_o !== 2'b00 || mem_resp_yumi_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_resp c=%0d: resp_v=%b yumi=%b expected 00/0", c, req_resp_v_o, mem_resp_yumi_o);
      end
      n_checks++;
      if (outstanding_o !== 3'd0 || error_o !== 1'b0 || timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state c=%0d: outstanding=%0d error=%b timeout=%b expected 0/0/0", c, outstanding_o, error_o, timeout_o);
      end
    end
    @(negedge clk_i);
    idle_inputs();
    reset_n_i = 1'b1;
  endtask

  task automatic test_rr_fairness();
    int           exp_port;
    logic [W-1:0] exp_cmd;
    logic [N-1:0] exp_v;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      idle_inputs();
      req_cmd_v_i     = 2'b11;
      mem_cmd_ready_i = 1'b1;
      for (int k = 0; k < N; k++) req_cmd_i[k*W +: W] = 32'h1000_0000 | (c << 8) | k;
      drive_mem_resp();
      #1;
      exp_port = c % 2;
      exp_cmd  = 32'h1000_0000 | (c << 8) | exp_port;
      n_checks++;
      if (req_cmd_ready_o !== (N'(1) << exp_port) || mem_cmd_o !== exp_cmd) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: ready=%b cmd=%h expected ready=%b cmd=%h", c, req_cmd_ready_o, mem_cmd_o, N'(1) << exp_port, exp_cmd);
      end
      if (mem_resp_v_i) begin
        exp_v = N'(1) << sb_q[0].port;
        n_checks++;
        if (req_resp_v_o !== exp_v || req_resp_o !== mem_fn(sb_q[0].cmd) || mem_resp_yumi_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_resp c=%0d: resp_v=%b data=%h yumi=%b expected %b/%h/1", c, req_resp_v_o, req_resp_o, mem_resp_yumi_o, exp_v, mem_fn(sb_q[0].cmd));
        end
        void'(sb_q.pop_front());
      end
      sb_q.push_back('{exp_port, exp_cmd});
    end
    drain_responses("rr");
  endtask

  task automatic test_routing();
    logic [W-1:0] a_cmd = 32'hAAAA_0001;
    logic [W-1:0] b_cmd = 32'hBBBB_0000;
    do_reset();
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b10; req_cmd_i[W +: W] = a_cmd; mem_cmd_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_cmd_ready_o !== 2'b10 || mem_cmd_o !== a_cmd) begin
      n_fail++;
      $display("FAIL route_issue_a: ready=%b cmd=%h expected 10/%h", req_cmd_ready_o, mem_cmd_o, a_cmd);
    end
    sb_q.push_back('{1, a_cmd});
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = b_cmd; mem_cmd_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_cmd_ready_o !== 2'b01 || mem_cmd_o !== b_cmd) begin
      n_fail++;
      $display("FAIL route_issue_b: ready=%b cmd=%h expected 01/%h", req_cmd_ready_o, mem_cmd_o, b_cmd);
    end
    sb_q.push_back('{0, b_cmd});
    // Wrong-port yumi must not consume the response owned by port 1
    @(negedge clk_i);
    idle_inputs();
    drive_mem_resp();
    req_resp_yumi_i = 2'b01;
    #1;
    n_checks++;
    if (req_resp_v_o !== 2'b10 || mem_resp_yumi_o !== 1'b0 || req_resp_o !== mem_fn(a_cmd)) begin
      n_fail++;
      $display("FAIL route_wrong_yumi: resp_v=%b yumi=%b data=%h expected 10/0/%h", req_resp_v_o, mem_resp_yumi_o, req_resp_o, mem_fn(a_cmd));
    end
    drain_responses("route");
  endtask

  task automatic test_full_fifo();
    logic [W-1:0] c4 = 32'h2000_0004;
    logic [W-1:0] c5 = 32'h2000_0005;
    do_reset();
    for (int c = 0; c < D; c++) begin
      @(negedge clk_i);
      idle_inputs();
      req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = 32'h2000_0000 + c; mem_cmd_ready_i = 1'b1;
      #1;
      n_checks++;
      if (req_cmd_ready_o !== 2'b01) begin
        n_fail++;
        $display("FAIL full_fill c=%0d: ready=%b expected 01", c, req_cmd_ready_o);
      end
      sb_q.push_back('{0, 32'h2000_0000 + c});
    end
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = c4; mem_cmd_ready_i = 1'b1;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd4 || mem_cmd_v_o !== 1'b0 || req_cmd_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL full_block: outstanding=%0d cmd_v=%b ready=%b expected 4/0/00", outstanding_o, mem_cmd_v_o, req_cmd_ready_o);
    end
    // Pop while full: the grant must still wait a cycle
    @(negedge clk_i);
    drive_mem_resp();
    #1;
    n_checks++;
    if (req_cmd_ready_o !== 2'b00 || mem_resp_yumi_o !== 1'b1 || req_resp_o !== mem_fn(sb_q[0].cmd)) begin
      n_fail++;
      $display("FAIL full_pop_no_grant: ready=%b yumi=%b data=%h expected 00/1/%h", req_cmd_ready_o, mem_resp_yumi_o, req_resp_o, mem_fn(sb_q[0].cmd));
    end
    void'(sb_q.pop_front());
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = c4; mem_cmd_ready_i = 1'b1;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd3 || req_cmd_ready_o !== 2'b01) begin
      n_fail++;
      $display("FAIL full_regrant: outstanding=%0d ready=%b expected 3/01", outstanding_o, req_cmd_ready_o);
    end
    sb_q.push_back('{0, c4});
    @(negedge clk_i);
    idle_inputs();
    drive_mem_resp();
    void'(sb_q.pop_front());
    @(negedge clk_i);
    idle_inputs();
    // Simultaneous push and pop keeps occupancy steady
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = c5; mem_cmd_ready_i = 1'b1;
    drive_mem_resp();
    #1;
    n_checks++;
    if (req_cmd_ready_o !== 2'b01 || mem_resp_yumi_o !== 1'b1 || req_resp_o !== mem_fn(sb_q[0].cmd)) begin
      n_fail++;
      $display("FAIL full_push_pop: ready=%b yumi=%b data=%h expected 01/1/%h", req_cmd_ready_o, mem_resp_yumi_o, req_resp_o, mem_fn(sb_q[0].cmd));
    end
    void'(sb_q.pop_front());
    sb_q.push_back('{0, c5});
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (outstanding_o !== 3'd3) begin
      n_fail++;
      $display("FAIL full_push_pop_count: outstanding=%0d expected 3", outstanding_o);
    end
    drain_responses("full");
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_error: error=%b expected 0", error_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = 32'h3000_0000; mem_cmd_ready_i = 1'b1;
    #1;
    sb_q.push_back('{0, 32'h3000_0000});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      idle_inputs();
      drive_mem_resp();
      req_resp_yumi_i = 2'b00;
      #1;
      n_checks++;
      if (req_resp_v_o !== 2'b01 || mem_resp_yumi_o !== 1'b0 || outstanding_o !== 3'd1) begin
        n_fail++;
        $display("FAIL bp_stall c=%0d: resp_v=%b yumi=%b outstanding=%0d expected 01/0/1", c, req_resp_v_o, mem_resp_yumi_o, outstanding_o);
      end
    end
    @(negedge clk_i);
    idle_inputs();
    drive_mem_resp();
    req_resp_yumi_i = 2'b01;
    #1;
    n_checks++;
    if (mem_resp_yumi_o !== 1'b1 || outstanding_o !== 3'd1) begin
      n_fail++;
      $display("FAIL bp_release: yumi=%b outstanding=%0d expected 1/1", mem_resp_yumi_o, outstanding_o);
    end
    void'(sb_q.pop_front());
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_decrement: outstanding=%0d expected 0", outstanding_o);
    end
  endtask

  task automatic test_error();
    do_reset();
    @(negedge clk_i);
    idle_inputs();
    mem_resp_v_i = 1'b1; mem_resp_i = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if (mem_resp_yumi_o !== 1'b1 || req_resp_v_o !== 2'b00 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_drop: yumi=%b resp_v=%b error=%b expected 1/00/0", mem_resp_yumi_o, req_resp_v_o, error_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: error=%b expected 1", error_o);
    end
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: error=%b expected 1", error_o);
    end
    // Reset with a command in flight: its late response is now spurious
    do_reset();
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b10; req_cmd_i[W +: W] = 32'h4000_0001; mem_cmd_ready_i = 1'b1;
    #1;
    @(negedge clk_i);
    idle_inputs();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL err_reset_flush: outstanding=%0d expected 0", outstanding_o);
    end
    @(negedge clk_i);
    reset_n_i    = 1'b1;
    mem_resp_v_i = 1'b1; mem_resp_i = mem_fn(32'h4000_0001); req_resp_yumi_i = 2'b11;
    #1;
    n_checks++;
    if (req_resp_v_o !== 2'b00 || mem_resp_yumi_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_late_resp: resp_v=%b yumi=%b expected 00/1", req_resp_v_o, mem_resp_yumi_o);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    n_checks++;
    if (error_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_late_set: error=%b expected 1", error_o);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    do_reset();
    @(negedge clk_i);
    idle_inputs();
    req_cmd_v_i = 2'b01; req_cmd_i[0 +: W] = 32'h5000_0000; mem_cmd_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_cmd_ready_o !== 2'b01 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_issue: ready=%b timeout=%b expected 01/0", req_cmd_ready_o, timeout_o);
    end
    cyc  = -1;
    seen = 1'b0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clk_i);
      idle_inputs();
      #1;
      if (timeout_o === 1'b1) begin
        seen = 1'b1;
        cyc  = j - 1;
      end
    end
    n_checks++;
    if (cyc !== T) begin
      n_fail++;
      $display("FAIL to_latency: timeout after %0d cycles expected %0d", cyc, T);
    end
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if (timeout_o !== 1'b1 || outstanding_o !== 3'd1 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: timeout=%b outstanding=%0d error=%b expected 1/1/0", timeout_o, outstanding_o, error_o);
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_fairness();
    test_routing();
    test_full_fifo();
    test_backpressure();
    test_error();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
